// File: rtl/frame_rx_deframer_if.sv
// Receive-side bundle between the line byte source, the deframer and the core.
// The deframer uses the slave modport; the source/consumer side uses master.
interface frame_rx_deframer_if #(
  parameter int FRAME_BYTES = 75
);
  localparam int FRAME_SIZE = FRAME_BYTES * 8 - 1;

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [0:FRAME_SIZE] frame_out;
  logic                frame_valid;
  logic                frame_ack;
  logic                err_valid;
  logic [7:0]          err_code;
  logic [15:0]         good_cnt;
  logic [15:0]         bad_cnt;

  modport master (
    output rx_data, rx_valid, frame_ack,
    input  frame_out, frame_valid, err_valid, err_code, good_cnt, bad_cnt
  );

  modport slave (
    input  rx_data, rx_valid, frame_ack,
    output frame_out, frame_valid, err_valid, err_code, good_cnt, bad_cnt
  );
endinterface

// File: rtl/frame_rx_deframer.sv
// Byte-serial deframer: hunts for FRAME_START, unstuffs, assembles a fixed-length
// frame, checks CRC-32 and holds the result on a wide bus until acknowledged.
module frame_rx_deframer #(
  parameter int DATA_SIZE     = 64,
  parameter int PREAMBLE_SIZE = 7,
  parameter int CRC_SIZE      = 4,
  parameter int FRAME_BYTES   = PREAMBLE_SIZE + DATA_SIZE + CRC_SIZE,
  parameter int FRAME_SIZE    = FRAME_BYTES * 8 - 1
) (
  input logic               clk,
  input logic               rst,
  frame_rx_deframer_if.slave bus
);
  localparam logic [7:0]  FRAME_START = 8'h06;
  localparam logic [7:0]  FRAME_END   = 8'h07;
  localparam logic [7:0]  ESC_BYTE    = 8'h14;
  localparam logic [7:0]  ESC_XOR     = 8'h20;
  localparam logic [7:0]  E_CRC       = 8'h01;
  localparam logic [7:0]  E_LEN       = 8'h02;
  localparam logic [7:0]  E_ESC       = 8'h03;
  localparam logic [7:0]  E_OVERRUN   = 8'h04;
  localparam logic [7:0]  E_ABORT     = 8'h05;
  localparam logic [31:0] POLY        = 32'h04C11DB7;
  localparam logic [6:0]  FULL_CNT    = 7'(FRAME_BYTES);
  localparam logic [6:0]  CRC_CNT     = 7'(PREAMBLE_SIZE + DATA_SIZE);
  localparam int          CRC_BIT     = (FRAME_BYTES - CRC_SIZE) * 8;

  typedef enum logic [1:0] {S_HUNT, S_RECV, S_ESC} state_t;

  state_t              state, state_nxt;
  logic [6:0]          byte_cnt;
  logic [31:0]         crc;
  logic [0:FRAME_SIZE] buffer;
  logic [9:0]          wr_bit;
  logic                store, clear, deliver, err;
  logic [7:0]          store_byte, code;
  logic                slot_busy;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic [7:0]  s;
    r = c;
    s = d;
    for (int unsigned i = 0; i < 8; i++) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ s[7]) ? POLY : '0);
      s = {s[6:0], 1'b0};
    end
    return r;
  endfunction

  assign wr_bit    = {byte_cnt, 3'b000};
  // An ack on the same edge as a delivery frees the slot for that delivery.
  assign slot_busy = bus.frame_valid && !bus.frame_ack;

  always_comb begin
    state_nxt  = state;
    store      = 1'b0;
    store_byte = bus.rx_data;
    clear      = 1'b0;
    deliver    = 1'b0;
    err        = 1'b0;
    code       = '0;
    if (bus.rx_valid) begin
      case (state)
        S_HUNT: begin
          if (bus.rx_data == FRAME_START) begin
            state_nxt = S_RECV;
            clear     = 1'b1;
          end
        end
        S_RECV: begin
          if (bus.rx_data == ESC_BYTE) begin
            state_nxt = S_ESC;
          end else if (bus.rx_data == FRAME_END) begin
            state_nxt = S_HUNT;
            if (byte_cnt != FULL_CNT) begin
              err  = 1'b1;
              code = E_LEN;
            end else if (crc != buffer[CRC_BIT +: 32]) begin
              err  = 1'b1;
              code = E_CRC;
            end else if (slot_busy) begin
              err  = 1'b1;
              code = E_OVERRUN;
            end else begin
              deliver = 1'b1;
            end
          end else if (bus.rx_data == FRAME_START) begin
            err   = 1'b1;
            code  = E_ABORT;
            clear = 1'b1;
          end else begin
            store = 1'b1;
          end
        end
        S_ESC: begin
          if (bus.rx_data == FRAME_START || bus.rx_data == FRAME_END ||
              bus.rx_data == ESC_BYTE) begin
            err       = 1'b1;
            code      = E_ESC;
            state_nxt = S_HUNT;
          end else begin
            store      = 1'b1;
            store_byte = bus.rx_data ^ ESC_XOR;
            state_nxt  = S_RECV;
          end
        end
        default: state_nxt = S_HUNT;
      endcase
      if (store && byte_cnt == FULL_CNT) begin
        store     = 1'b0;
        err       = 1'b1;
        code      = E_LEN;
        state_nxt = S_HUNT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_HUNT;
      byte_cnt        <= '0;
      crc             <= '0;
      buffer          <= '0;
      bus.frame_out   <= '0;
      bus.frame_valid <= 1'b0;
      bus.err_valid   <= 1'b0;
      bus.err_code    <= '0;
      bus.good_cnt    <= '0;
      bus.bad_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      bus.err_valid <= err;
      bus.err_code  <= code;
      if (err && bus.bad_cnt != '1) bus.bad_cnt <= bus.bad_cnt + 16'd1;

      if (clear) begin
        byte_cnt <= '0;
        crc      <= '0;
      end else if (store) begin
        buffer[wr_bit +: 8] <= store_byte;
        byte_cnt            <= byte_cnt + 7'd1;
        if (byte_cnt < CRC_CNT) crc <= crc_step(crc, store_byte);
      end

      if (deliver) begin
        bus.frame_out   <= buffer;
        bus.frame_valid <= 1'b1;
        if (bus.good_cnt != '1) bus.good_cnt <= bus.good_cnt + 16'd1;
      end else if (bus.frame_valid && bus.frame_ack) begin
        bus.frame_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/frame_rx_deframer.md
# frame_rx_deframer

Byte-serial receive deframer sitting directly upstream of the core frame processor on each side (jawny and tajny are separate instances). It hunts for FRAME_START, removes byte stuffing, assembles a fixed-length frame, checks the CRC-32, and presents the completed frame on a wide parallel bus. The bus is held until the core acknowledges it. Framing, length, escape, CRC and overrun faults are reported as one-cycle error pulses with a code.

## Interface
- DATA_SIZE, 64: payload bytes per frame.
- PREAMBLE_SIZE, 7: header bytes. Byte 0 is the frame type; bytes 3..6 are the big-endian frame number.
- CRC_SIZE, 4: trailing CRC bytes.
- FRAME_BYTES, PREAMBLE_SIZE+DATA_SIZE+CRC_SIZE (75): unstuffed frame length.
- FRAME_SIZE, FRAME_BYTES*8-1 (599): MSB index of the frame bus.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  line byte.
- rx_valid  in  1  rx_data is valid this cycle. There is no backpressure; every valid byte is consumed.
- frame_out  out  [0:FRAME_SIZE]  assembled frame. Byte k occupies bits [8k:8k+7], MSB first.
- frame_valid  out  1  frame_out holds a checked frame; level-held until acknowledged.
- frame_ack  in  1  consumer took frame_out; sampled only while frame_valid=1.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  8  error cause. Valid with err_valid; otherwise 0x00.
- good_cnt  out  16  frames delivered, saturating at 0xFFFF.
- bad_cnt  out  16  error pulses issued, saturating at 0xFFFF.

## Operation
- Flag bytes: FRAME_START=0x06, FRAME_END=0x07, ESC=0x14. An escaped byte is the next byte XOR 0x20.
- States:
  - HUNT: discard all bytes except 0x06, which moves to RECV.
  - RECV: 0x14 moves to ESC. 0x07 triggers the end check. 0x06 signals ABORT (0x05), clears the buffer and stays in RECV. Any other byte is stored.
  - ESC: 0x06, 0x07 or 0x14 signal ESC error (0x03) and go to HUNT. Any other byte is stored XOR 0x20 and returns to RECV.
- Storing a byte:
  - Write it to assembly buffer byte index byte_cnt, then increment byte_cnt (7 bits).
  - Storing a 76th byte signals LEN error (0x02) and goes to HUNT; the byte is discarded.
- End check on 0x07:
  - If byte_cnt != FRAME_BYTES: LEN error (0x02), go to HUNT.
  - Otherwise compare the running CRC against bytes 71..74 (big-endian). A mismatch signals CRC error (0x01).
  - On a match, deliver the frame if the output slot is free, else signal OVERRUN (0x04) and drop the frame.
  - Every outcome returns to HUNT.
- CRC:
  - CRC-32, poly 0x04C11DB7, init 0x00000000, MSB-first, unreflected, no final XOR.
  - Covers unstuffed bytes 0..70. It is updated byte-wise (8 unrolled shift steps) as each byte is stored.
  - The CRC is cleared whenever byte_cnt is cleared.
- Output slot: frame_out is a separate register from the assembly buffer and is loaded only on delivery.
  - frame_out is stable while frame_valid=1.
  - It keeps its last value after ack. No content checks (type, sequence) are done here; those belong to the core.
- Each delivery increments good_cnt; each err_valid increments bad_cnt.
- Reset: state=HUNT, byte_cnt=0, CRC=0. All outputs go to 0: frame_out all zero, frame_valid=0, err_valid=0, err_code=0x00, good_cnt=0, bad_cnt=0.

## Timing
- Byte accepted at edge N → state, buffer and CRC updated at N; no bubbles; back-to-back rx_valid is supported.
- FRAME_END accepted at edge N → frame_valid=1 (or err_valid=1) visible after edge N. Latency is 1 cycle from the last byte.
- err_valid is high for exactly one cycle per error. Errors from consecutive bytes produce consecutive pulses.
- frame_ack=1 at edge M while frame_valid=1 → frame_valid=0 after M.
- Ack and a new delivery on the same edge: the slot counts as free. The new frame loads, frame_valid stays 1 and no OVERRUN is signalled.
- frame_ack while frame_valid=0 is ignored.
- Reset asserted mid-frame or mid-hold: outputs clear immediately (asynchronous), the partial frame is lost, and hunting resumes on the first edge after deassertion.

## Test plan
- Good frame: 0x06, 75 bytes (type 0x00, frame number 0x00000001, payload 0x00..0x3F, correct CRC), 0x07 → frame_valid=1 one cycle after 0x07; frame_out[0:7]=0x00, [24:55]=0x00000001; good_cnt=1, err_valid never high.
- Stuffing: payload bytes 0x06, 0x07, 0x14 sent as 0x14 0x26, 0x14 0x27, 0x14 0x34 → frame_out holds 0x06, 0x07, 0x14 at those indices and the CRC passes; separately, 0x14 0x07 → err_code=0x03 and state HUNT.
- Length: END after 74 bytes → err_code=0x02. Then 76 stored bytes → err_code=0x02 on the 76th. frame_valid stays 0 and bad_cnt=2.
- CRC: good frame with payload byte 10 flipped → err_code=0x01, frame_valid=0, good_cnt unchanged.
- Hold/overrun: two good frames with no ack → first frame held unchanged, second gives err_code=0x04. Repeat with frame_ack on the second frame's 0x07-accept edge → frame_out=second frame, frame_valid continuously 1, no error.
- Reset/abort: 0x06 mid-frame → err_code=0x05 and the following frame delivers correctly. rst pulsed mid-frame → all outputs 0 immediately, then the next full frame delivers with good_cnt=1.
